// File: rtl/sensor_frame_aligner.sv
// Buffers one timestamped sample per sensor channel, checks the timestamp span against a window,
// and emits one packed fused frame over valid/ready. Stale samples are dropped; timeouts flush.
module sensor_frame_aligner #(
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 512,
    parameter int TS_W       = 32,
    parameter int WINDOW     = 100,
    parameter int TIMEOUT    = 1024,
    parameter int PARTIAL_EN = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_CH*CH_W-1:0] in_data,
    input  logic [NUM_CH*TS_W-1:0] in_ts,
    input  logic [NUM_CH-1:0]      in_valid,
    output logic [NUM_CH-1:0]      in_ready,
    output logic [NUM_CH*CH_W-1:0] out_data,
    output logic [TS_W-1:0]        out_ts,
    output logic [NUM_CH-1:0]      out_mask,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_partial,
    output logic [15:0]            drop_cnt
);

    localparam int TMR_W = $clog2(TIMEOUT);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TS_W-1:0]  WIN      = TS_W'(WINDOW);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        EMIT
    } state_t;

    state_t state;
    state_t state_next;

    logic [CH_W-1:0]   slot_data [NUM_CH];
    logic [TS_W-1:0]   slot_ts   [NUM_CH];
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] accept;
    logic [NUM_CH-1:0] remain;
    logic              run;
    logic [TMR_W-1:0]  timer;

    logic [IDX_W-1:0]  oldest_idx;
    logic [IDX_W-1:0]  newest_idx;
    logic              found;
    logic [TS_W-1:0]   oldest_ts;
    logic [TS_W-1:0]   span;

    logic all_full;
    logic any_accept;
    logic emit_full;
    logic drop_oldest;
    logic timeout_hit;
    logic handshake;
    logic capture;
    logic flush_discard;

    logic [15:0] drop_inc;
    logic [16:0] drop_sum;

    // Modular age test: a is older than (or equal to) b when b - a lands in the lower half-range.
    function automatic logic is_older(input logic [TS_W-1:0] a, input logic [TS_W-1:0] b);
        logic [TS_W-1:0] diff;
        diff = b - a;
        return ~diff[TS_W-1];
    endfunction

    assign accept        = in_valid & in_ready;
    assign any_accept    = |accept;
    assign all_full      = &full;
    assign emit_full     = (state == COLLECT) && all_full && (span <= WIN);
    assign drop_oldest   = (state == COLLECT) && all_full && (span > WIN);
    assign timeout_hit   = (state == COLLECT) && !all_full && (timer == TMR_LAST);
    assign handshake     = (state == EMIT) && out_ready;
    assign capture       = emit_full || (timeout_hit && (PARTIAL_EN != 0));
    assign flush_discard = timeout_hit && (PARTIAL_EN == 0);
    assign remain        = full & ~out_mask;

    always_comb begin
        oldest_idx = '0;
        newest_idx = '0;
        found      = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (full[i]) begin
                if (!found) begin
                    oldest_idx = IDX_W'(i);
                    newest_idx = IDX_W'(i);
                    found      = 1'b1;
                end else begin
                    if ((slot_ts[i] != slot_ts[oldest_idx]) && is_older(slot_ts[i], slot_ts[oldest_idx]))
                        oldest_idx = IDX_W'(i);
                    if ((slot_ts[i] != slot_ts[newest_idx]) && is_older(slot_ts[newest_idx], slot_ts[i]))
                        newest_idx = IDX_W'(i);
                end
            end
        end
        oldest_ts = slot_ts[oldest_idx];
        span      = slot_ts[newest_idx] - slot_ts[oldest_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Slots filled in the same cycle as a partial flush survive the handshake and restart collection.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (any_accept)
                    state_next = COLLECT;
            end
            COLLECT: begin
                if (emit_full)
                    state_next = EMIT;
                else if (timeout_hit) begin
                    if (PARTIAL_EN != 0)
                        state_next = EMIT;
                    else if (!any_accept)
                        state_next = IDLE;
                end
            end
            EMIT: begin
                if (out_ready)
                    state_next = (|remain) ? COLLECT : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == EMIT);
        in_ready  = '0;
        if (run && (state != EMIT))
            in_ready = ~full;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            run <= 1'b0;
        else
            run <= 1'b1;
    end

    // The timer saturates so a drop landing on the last tick still leads to a timeout next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            timer <= '0;
        else if ((state != COLLECT) || (state_next != COLLECT) || timeout_hit)
            timer <= '0;
        else if (timer != TMR_LAST)
            timer <= timer + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                slot_data[i] <= '0;
                slot_ts[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (accept[i]) begin
                    full[i]      <= 1'b1;
                    slot_data[i] <= in_data[i*CH_W +: CH_W];
                    slot_ts[i]   <= in_ts[i*TS_W +: TS_W];
                end else if ((drop_oldest && (oldest_idx == IDX_W'(i))) || flush_discard ||
                             (handshake && out_mask[i])) begin
                    full[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data    <= '0;
            out_ts      <= '0;
            out_mask    <= '0;
            out_partial <= 1'b0;
        end else if (capture) begin
            for (int i = 0; i < NUM_CH; i++)
                out_data[i*CH_W +: CH_W] <= full[i] ? slot_data[i] : '0;
            out_ts      <= oldest_ts;
            out_mask    <= full;
            out_partial <= !all_full;
        end
    end

    always_comb begin
        drop_inc = '0;
        if (drop_oldest)
            drop_inc = 16'd1;
        else if (flush_discard) begin
            for (int i = 0; i < NUM_CH; i++)
                drop_inc = drop_inc + {15'd0, full[i]};
        end
        drop_sum = {1'b0, drop_cnt} + {1'b0, drop_inc};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_cnt <= '0;
        else
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_ts) &&
                                       $stable(out_mask) && $stable(out_partial)));

    a_no_ready_in_emit: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid |-> (in_ready == '0));

endmodule

// File: tb/tb_sensor_frame_aligner.sv
// Scoreboard bench for sensor_frame_aligner: directed vectors push expected frames, a negedge monitor
// pops and compares on every output handshake. A second instance covers the discard-on-timeout mode.
module tb_sensor_frame_aligner;

    localparam int NUM_CH  = 4;
    localparam int CH_W    = 512;
    localparam int TS_W    = 32;
    localparam int WINDOW  = 100;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [NUM_CH*CH_W-1:0] in_data_a,  in_data_b;
    logic [NUM_CH*TS_W-1:0] in_ts_a,    in_ts_b;
    logic [NUM_CH-1:0]      in_valid_a, in_valid_b;
    logic [NUM_CH-1:0]      in_ready_a, in_ready_b;
    logic [NUM_CH*CH_W-1:0] out_data_a, out_data_b;
    logic [TS_W-1:0]        out_ts_a,   out_ts_b;
    logic [NUM_CH-1:0]      out_mask_a, out_mask_b;
    logic                   out_valid_a, out_valid_b;
    logic                   out_ready_a, out_ready_b;
    logic                   out_partial_a, out_partial_b;
    logic [15:0]            drop_cnt_a, drop_cnt_b;

    sensor_frame_aligner #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .TS_W(TS_W), .WINDOW(WINDOW), .TIMEOUT(TIMEOUT), .PARTIAL_EN(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_a), .in_ts(in_ts_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .out_data(out_data_a), .out_ts(out_ts_a), .out_mask(out_mask_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_partial(out_partial_a), .drop_cnt(drop_cnt_a)
    );

    sensor_frame_aligner #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .TS_W(TS_W), .WINDOW(WINDOW), .TIMEOUT(TIMEOUT), .PARTIAL_EN(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_b), .in_ts(in_ts_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .out_data(out_data_b), .out_ts(out_ts_b), .out_mask(out_mask_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_partial(out_partial_b), .drop_cnt(drop_cnt_b)
    );

    typedef struct {
        logic [NUM_CH*CH_W-1:0] data;
        logic [TS_W-1:0]        ts;
        logic [NUM_CH-1:0]      mask;
        logic                   partial;
    } frame_t;

    frame_t          exp_q[$];
    frame_t          exp_frame;
    frame_t          held;
    bit              hold_prev = 1'b0;
    logic [CH_W-1:0] model_data [NUM_CH];
    int              vectors = 0;
    int              miscompares = 0;

    function automatic logic [CH_W-1:0] mk(input int ch, input int tag);
        logic [31:0] w;
        w = {8'(ch + 1), 24'(tag)};
        return {(CH_W/32){w}};
    endfunction

    task automatic check_output(input string name, input logic [CH_W-1:0] act, input logic [CH_W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one cycle of samples; the model remembers what was sent on instance a.
    task automatic apply_stimulus(input bit to_b, input logic [3:0] mask, input logic [31:0] t0,
                                  input logic [31:0] t1, input logic [31:0] t2, input logic [31:0] t3,
                                  input int tag);
        logic [3:0][31:0] ts;
        ts = {t3, t2, t1, t0};
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (mask[ch]) begin
                if (to_b) begin
                    in_data_b[ch*CH_W +: CH_W] = mk(ch, tag);
                    in_ts_b[ch*TS_W +: TS_W]   = ts[ch];
                end else begin
                    in_data_a[ch*CH_W +: CH_W] = mk(ch, tag);
                    in_ts_a[ch*TS_W +: TS_W]   = ts[ch];
                    model_data[ch]             = mk(ch, tag);
                end
            end
        end
        if (to_b) in_valid_b = mask;
        else      in_valid_a = mask;
        step(1);
        in_valid_a = '0;
        in_valid_b = '0;
    endtask

    task automatic expect_frame(input logic [3:0] mask, input logic [31:0] ts, input logic partial);
        frame_t f;
        f.data = '0;
        for (int ch = 0; ch < NUM_CH; ch++)
            if (mask[ch]) f.data[ch*CH_W +: CH_W] = model_data[ch];
        f.ts      = ts;
        f.mask    = mask;
        f.partial = partial;
        exp_q.push_back(f);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid_a && n < 40) begin
            step(1);
            n++;
        end
        check_output(name, CH_W'(out_valid_a), CH_W'(1));
    endtask

    task automatic wait_frame(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            step(1);
            n++;
        end
        check_output(name, CH_W'(exp_q.size()), '0);
        exp_q.delete();
    endtask

    task automatic check_idle_zero(input string tag);
        check_output({tag, "_out_valid"}, CH_W'(out_valid_a), '0);
        check_output({tag, "_in_ready"}, CH_W'(in_ready_a), '0);
        check_output({tag, "_out_ts"}, CH_W'(out_ts_a), '0);
        check_output({tag, "_out_mask"}, CH_W'(out_mask_a), '0);
        check_output({tag, "_out_partial"}, CH_W'(out_partial_a), '0);
        check_output({tag, "_drop_cnt"}, CH_W'(drop_cnt_a), '0);
        for (int ch = 0; ch < NUM_CH; ch++)
            check_output($sformatf("%s_out_data_ch%0d", tag, ch), out_data_a[ch*CH_W +: CH_W], '0);
    endtask

    // Monitor: hold-stability and in_ready checks while valid, scoreboard pop on each handshake.
    always @(negedge clk) begin
        if (!rst_n || !out_valid_a) begin
            hold_prev = 1'b0;
        end else begin
            check_output("in_ready_emit", CH_W'(in_ready_a), '0);
            if (hold_prev) begin
                check_output("hold_ts", CH_W'(out_ts_a), CH_W'(held.ts));
                check_output("hold_mask", CH_W'(out_mask_a), CH_W'(held.mask));
                check_output("hold_partial", CH_W'(out_partial_a), CH_W'(held.partial));
                for (int ch = 0; ch < NUM_CH; ch++)
                    check_output($sformatf("hold_data_ch%0d", ch), out_data_a[ch*CH_W +: CH_W],
                                 held.data[ch*CH_W +: CH_W]);
            end
            if (out_ready_a) begin
                hold_prev = 1'b0;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_frame: got mask %0h ts %0h, expected no frame",
                             out_mask_a, out_ts_a);
                end else begin
                    exp_frame = exp_q.pop_front();
                    check_output("frame_ts", CH_W'(out_ts_a), CH_W'(exp_frame.ts));
                    check_output("frame_mask", CH_W'(out_mask_a), CH_W'(exp_frame.mask));
                    check_output("frame_partial", CH_W'(out_partial_a), CH_W'(exp_frame.partial));
                    for (int ch = 0; ch < NUM_CH; ch++)
                        check_output($sformatf("frame_data_ch%0d", ch), out_data_a[ch*CH_W +: CH_W],
                                     exp_frame.data[ch*CH_W +: CH_W]);
                end
            end else begin
                hold_prev    = 1'b1;
                held.data    = out_data_a;
                held.ts      = out_ts_a;
                held.mask    = out_mask_a;
                held.partial = out_partial_a;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic any_valid;
        rst_n       = 1'b0;
        in_data_a   = '0;  in_data_b  = '0;
        in_ts_a     = '0;  in_ts_b    = '0;
        in_valid_a  = '0;  in_valid_b = '0;
        out_ready_a = 1'b1;
        out_ready_b = 1'b1;
        for (int ch = 0; ch < NUM_CH; ch++) model_data[ch] = '0;
        step(3);

        $display("[TB] reset state");
        check_idle_zero("reset");
        rst_n = 1'b1;
        check_output("ready_before_edge", CH_W'(in_ready_a), '0);
        step(1);
        check_output("ready_after_release_a", CH_W'(in_ready_a), CH_W'(4'hF));
        check_output("ready_after_release_b", CH_W'(in_ready_b), CH_W'(4'hF));

        $display("[TB] test 1: all channels in one cycle");
        apply_stimulus(0, 4'hF, 100, 120, 150, 180, 11);
        expect_frame(4'hF, 100, 1'b0);
        check_output("t1_valid_not_yet", CH_W'(out_valid_a), '0);
        step(1);
        check_output("t1_valid_latency", CH_W'(out_valid_a), CH_W'(1));
        step(1);
        check_output("t1_ready_after_hs", CH_W'(in_ready_a), CH_W'(4'hF));
        wait_frame("t1_frame_done");

        $display("[TB] test 2: staggered arrivals, backpressure");
        out_ready_a = 1'b0;
        apply_stimulus(0, 4'b0001, 1000, 0, 0, 0, 21);
        step(2);
        apply_stimulus(0, 4'b0010, 0, 1010, 0, 0, 22);
        step(3);
        apply_stimulus(0, 4'b0100, 0, 0, 1040, 0, 23);
        step(1);
        apply_stimulus(0, 4'b1000, 0, 0, 0, 1090, 24);
        expect_frame(4'hF, 1000, 1'b0);
        wait_valid("t2_valid");
        step(5);
        check_output("t2_still_valid", CH_W'(out_valid_a), CH_W'(1));
        out_ready_a = 1'b1;
        wait_frame("t2_frame_done");
        check_output("t2_slots_clear", CH_W'(in_ready_a), CH_W'(4'hF));

        $display("[TB] test 3: stale sample drops");
        apply_stimulus(0, 4'hF, 0, 50, 200, 210, 31);
        step(1);
        check_output("t3_drop1_cnt", CH_W'(drop_cnt_a), CH_W'(1));
        check_output("t3_drop1_ready", CH_W'(in_ready_a), CH_W'(4'b0001));
        apply_stimulus(0, 4'b0001, 205, 0, 0, 0, 32);
        step(1);
        check_output("t3_drop2_cnt", CH_W'(drop_cnt_a), CH_W'(2));
        check_output("t3_drop2_ready", CH_W'(in_ready_a), CH_W'(4'b0010));
        apply_stimulus(0, 4'b0010, 0, 202, 0, 0, 33);
        expect_frame(4'hF, 200, 1'b0);
        wait_frame("t3_frame_done");
        check_output("t3_drop_final", CH_W'(drop_cnt_a), CH_W'(2));

        $display("[TB] test 4a: partial frame on timeout");
        apply_stimulus(0, 4'b1010, 0, 500, 0, 510, 41);
        for (int i = 0; i < 14; i++) begin
            step(1);
            check_output($sformatf("t4_no_early_valid_%0d", i), CH_W'(out_valid_a), '0);
        end
        expect_frame(4'b1010, 500, 1'b1);
        wait_frame("t4_partial_done");
        check_output("t4_ready_after", CH_W'(in_ready_a), CH_W'(4'hF));

        $display("[TB] test 4b: discard on timeout");
        any_valid = 1'b0;
        apply_stimulus(1, 4'b1010, 0, 500, 0, 510, 42);
        for (int i = 0; i < 20; i++) begin
            step(1);
            any_valid = any_valid | out_valid_b;
            if (i == 9) begin
                check_output("t4b_cnt_before", CH_W'(drop_cnt_b), '0);
                check_output("t4b_ready_before", CH_W'(in_ready_b), CH_W'(4'b0101));
            end
        end
        check_output("t4b_no_frame", CH_W'(any_valid), '0);
        check_output("t4b_drop_cnt", CH_W'(drop_cnt_b), CH_W'(2));
        check_output("t4b_idle_ready", CH_W'(in_ready_b), CH_W'(4'hF));

        $display("[TB] test 5: timestamp wrap-around");
        apply_stimulus(0, 4'hF, 32'hFFFF_FFC0, 32'hFFFF_FFF0, 32'h0000_0010, 32'h0000_0020, 51);
        expect_frame(4'hF, 32'hFFFF_FFC0, 1'b0);
        wait_frame("t5_frame_done");
        check_output("t5_no_drop", CH_W'(drop_cnt_a), CH_W'(2));

        $display("[TB] test 6: reset during emit and with partial fill");
        out_ready_a = 1'b0;
        apply_stimulus(0, 4'hF, 10, 20, 30, 40, 61);
        wait_valid("t6_valid");
        rst_n = 1'b0;
        #1;
        check_idle_zero("t6_emit_reset");
        step(1);
        rst_n = 1'b1;
        step(1);
        check_output("t6_ready_release1", CH_W'(in_ready_a), CH_W'(4'hF));
        apply_stimulus(0, 4'b0011, 60, 70, 0, 0, 62);
        check_output("t6_two_full", CH_W'(in_ready_a), CH_W'(4'b1100));
        rst_n = 1'b0;
        #1;
        check_output("t6_ready_in_reset", CH_W'(in_ready_a), '0);
        step(1);
        rst_n = 1'b1;
        step(1);
        check_output("t6_slots_cleared", CH_W'(in_ready_a), CH_W'(4'hF));
        out_ready_a = 1'b1;
        apply_stimulus(0, 4'hF, 300, 310, 320, 330, 63);
        expect_frame(4'hF, 300, 1'b0);
        wait_frame("t6_fresh_frame");

        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
